// File: rtl/swc_dec_pkg.sv
// swc_dec_pkg: shared encodings, op indices and FSM state for the SwitchMCU register-register decoder
package swc_dec_pkg;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam int N_OPS   = 10;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLL  = 2;
  localparam int OP_SLT  = 3;
  localparam int OP_SLTU = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_OR   = 8;
  localparam int OP_AND  = 9;
  typedef enum logic [1:0] {EMPTY, VALID, STALL} dec_state_t;
endpackage

// File: rtl/dec_rtype_swc.sv
// dec_rtype_swc: combinational RV32I OP-group decoder
//   instr_i   : 32-bit instruction word
//   op_o      : one-hot op select (bit order as OP_* in swc_dec_pkg), zero when illegal
//   rs1_o/rs2_o/rd_o : register index fields
//   illegal_o : word is not a legal OP-group instruction
module dec_rtype_swc
  import swc_dec_pkg::*;
(
  input  logic [31:0]      instr_i,
  output logic [N_OPS-1:0] op_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic             illegal_o
);
  logic [6:0] f7;
  logic [2:0] f3;
  logic alt, f7_ok;
  logic [N_OPS-1:0] raw;
  assign f7 = instr_i[31:25];
  assign f3 = instr_i[14:12];
  assign alt = f7 == F7_ALT;
  // The alternate funct7 only exists for sub and sra.
  assign f7_ok = (f7 == F7_BASE) || (alt && (f3 == F3_ADD || f3 == F3_SRL));
  assign illegal_o = !((instr_i[6:0] == OPC_OP) && f7_ok);
  assign raw[OP_ADD]  = f3 == F3_ADD && !alt;
  assign raw[OP_SUB]  = f3 == F3_ADD && alt;
  assign raw[OP_SLL]  = f3 == F3_SLL;
  assign raw[OP_SLT]  = f3 == F3_SLT;
  assign raw[OP_SLTU] = f3 == F3_SLTU;
  assign raw[OP_XOR]  = f3 == F3_XOR;
  assign raw[OP_SRL]  = f3 == F3_SRL && !alt;
  assign raw[OP_SRA]  = f3 == F3_SRL && alt;
  assign raw[OP_OR]   = f3 == F3_OR;
  assign raw[OP_AND]  = f3 == F3_AND;
  assign op_o  = illegal_o ? '0 : raw;
  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];
  assign rd_o  = instr_i[11:7];
endmodule

// File: rtl/dec_reg_swc.sv
// dec_reg_swc: slot-phased register-register decode stage feeding the execute unit
//   hclk/hrstn     : clock, async active-low reset
//   cycle_cnt      : slot phase 1..4 (0 in reset)
//   ifu_*          : fetch handshake (valid/instr/pc in, ready out)
//   exu_stall      : execute stall, sampled at phase-4 edges only
//   en, dec_*      : held instruction valid, one-hot op, register fields
//   pc             : PC of held instruction
//   dec_illegal    : one-cycle pulse after capturing a non-OP word
//   issue_cnt      : legal instructions issued (wrapping)
module dec_reg_swc
  import swc_dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            hclk,
  input  logic            hrstn,
  input  logic [3:0]      cycle_cnt,
  input  logic            ifu_valid,
  input  logic [31:0]     ifu_instr,
  input  logic [XLEN-1:0] ifu_pc,
  output logic            ifu_ready,
  input  logic            exu_stall,
  output logic            en,
  output logic            dec_add,
  output logic            dec_sub,
  output logic            dec_sll,
  output logic            dec_slt,
  output logic            dec_sltu,
  output logic            dec_xor,
  output logic            dec_srl,
  output logic            dec_sra,
  output logic            dec_or,
  output logic            dec_and,
  output logic [4:0]      dec_rs1,
  output logic [4:0]      dec_rs2,
  output logic [4:0]      dec_rd,
  output logic [XLEN-1:0] pc,
  output logic            dec_illegal,
  output logic [XLEN-1:0] issue_cnt
);
  dec_state_t state_q, state_d;
  logic [N_OPS-1:0] op_q, op_d, dec_op;
  logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, dec_rs1_w, dec_rs2_w, dec_rd_w;
  logic [XLEN-1:0] pc_q, pc_d, cnt_q, cnt_d;
  logic ill_q, ill_d, dec_ill, cap, ph4;
  dec_rtype_swc u_dec (
    .instr_i   (ifu_instr),
    .op_o      (dec_op),
    .rs1_o     (dec_rs1_w),
    .rs2_o     (dec_rs2_w),
    .rd_o      (dec_rd_w),
    .illegal_o (dec_ill)
  );
  assign ifu_ready = (state_q == EMPTY) && (cycle_cnt == 4'd1);
  assign cap = ifu_ready && ifu_valid;
  assign ph4 = cycle_cnt == 4'd4;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rd_d = rd_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    ill_d = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (cap && dec_ill) ill_d = 1'b1;
        else if (cap) begin
          state_d = VALID;
          op_d = dec_op;
          rs1_d = dec_rs1_w;
          rs2_d = dec_rs2_w;
          rd_d = dec_rd_w;
          pc_d = ifu_pc;
          cnt_d = cnt_q + XLEN'(1);
        end
      end
      VALID: begin
        if (ph4) state_d = exu_stall ? STALL : EMPTY;
        if (ph4 && !exu_stall) op_d = '0;
      end
      STALL: begin
        if (ph4 && !exu_stall) begin
          state_d = EMPTY;
          op_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        op_d = '0;
      end
    endcase
  end
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q <= EMPTY;
      op_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q <= '0;
      pc_q <= '0;
      cnt_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q <= rd_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      ill_q <= ill_d;
    end
  end
  assign en = state_q != EMPTY;
  assign {dec_and, dec_or, dec_sra, dec_srl, dec_xor, dec_sltu, dec_slt, dec_sll, dec_sub, dec_add} = op_q;
  assign dec_rs1 = rs1_q;
  assign dec_rs2 = rs2_q;
  assign dec_rd = rd_q;
  assign pc = pc_q;
  assign dec_illegal = ill_q;
  assign issue_cnt = cnt_q;
endmodule
